// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units:
// controller state encoding and counter sizing helper.
package serial_arith_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

   // One spare bit so power-of-two widths do not wrap to zero.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_add_sub_full_adder_cell.sv
// Single-bit full adder assembled from two half-adder cells
// and an OR gate on the two partial carries.
module half_adder_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_s0;
   logic w_c0;
   logic w_c1;

   half_adder_cell u_ha0 (
      .a (a),
      .b (b),
      .s (w_s0),
      .c (w_c0)
   );

   half_adder_cell u_ha1 (
      .a (w_s0),
      .b (cin),
      .s (s),
      .c (w_c1)
   );

   assign cout = w_c0 | w_c1;

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first,
// WIDTH clocks per operation, result and flags registered at the end.
module serial_add_sub
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_busy;
   logic             r_done;
   logic             r_cout;
   logic             r_ovf;

   logic             w_s;
   logic             w_c;
   logic [WIDTH-1:0] w_res_next;

   full_adder_cell u_fa (
      .a    (r_opa[0]),
      .b    (r_opb[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   assign w_res_next = {w_s, r_res[WIDTH-1:1]};

   // Controller, operand shifters and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_opa   <= '0;
         r_opb   <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_opa   <= a;
                  r_opb   <= b ^ {WIDTH{sub}};
                  r_carry <= sub;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_opa   <= r_opa >> 1;
               r_opb   <= r_opb >> 1;
               r_res   <= w_res_next;
               r_carry <= w_c;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  // r_carry here is the carry into the MSB.
                  r_sum   <= w_res_next;
                  r_cout  <= w_c;
                  r_ovf   <= r_carry ^ w_c;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub at WIDTH 8, 16 and 2:
// directed cases, reset abort, back-to-back handshake, random sweeps.
module tb_serial_add_sub;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      int          t;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start8 = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, cout8, ovf8;
   logic [7:0]  sum8;

   logic        start16 = 1'b0, sub16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, cout16, ovf16;
   logic [15:0] sum16;

   logic        start2 = 1'b0, sub2 = 1'b0;
   logic [1:0]  a2 = '0, b2 = '0;
   logic        busy2, done2, cout2, ovf2;
   logic [1:0]  sum2;

   exp_t        q8[$], q16[$], q2[$];
   exp_t        e8, e16, e2;
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          bcnt8 = 0;
   int          n_done8 = 0;
   int          nd0;
   logic [63:0] last8 = '0;
   logic        stab_en = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   serial_add_sub #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8),
      .a(a8), .b(b8), .busy(busy8), .done(done8),
      .sum(sum8), .cout(cout8), .overflow(ovf8)
   );

   serial_add_sub #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .start(start16), .sub(sub16),
      .a(a16), .b(b16), .busy(busy16), .done(done16),
      .sum(sum16), .cout(cout16), .overflow(ovf16)
   );

   serial_add_sub #(.WIDTH(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .sub(sub2),
      .a(a2), .b(b2), .busy(busy2), .done(done2),
      .sum(sum2), .cout(cout2), .overflow(ovf2)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, input int w, input int t);
      exp_t        e;
      logic [63:0] mask;
      logic [63:0] bb;
      logic [64:0] full;
      logic        sa, sb, ss;
      mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      bb     = (sub ? ~b : b) & mask;
      full   = {1'b0, a & mask} + {1'b0, bb} + 65'(sub);
      e.sum  = full[63:0] & mask;
      e.cout = full[w];
      sa     = a[w-1];
      sb     = bb[w-1];
      ss     = e.sum[w-1];
      e.ovf  = (sa == sb) && (ss != sa);
      e.t    = t;
      return e;
   endfunction

   task automatic drain8();
      int n = 0;
      while (q8.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain8", 64'(q8.size()), 64'd0);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [7:0] esum,
                      input logic ecout, input logic eovf);
      exp_t e;
      a8 = a;
      b8 = b;
      sub8 = s;
      start8 = 1'b1;
      e.sum = 64'(esum);
      e.cout = ecout;
      e.ovf = eovf;
      e.t = cyc;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
      a8 = ~a;
      b8 = ~b;
      sub8 = ~s;
      drain8();
   endtask

   // WIDTH=8 monitor: result, latency, busy length, sum stability.
   always @(negedge clk) begin
      if (rst) begin
         bcnt8 = 0;
         last8 = '0;
      end else begin
         if (busy8) bcnt8++;
         if (done8) begin
            n_done8++;
            if (q8.size() == 0) begin
               chk("spur8", 64'd1, 64'd0);
            end else begin
               e8 = q8.pop_front();
               chk("sum8", 64'(sum8), e8.sum);
               chk("cout8", 64'(cout8), 64'(e8.cout));
               chk("ovf8", 64'(ovf8), 64'(e8.ovf));
               chk("lat8", 64'(cyc - e8.t), 64'd9);
               chk("busy8", 64'(bcnt8), 64'd8);
               last8 = e8.sum;
            end
            bcnt8 = 0;
         end else if (stab_en) begin
            chk("stab8", 64'(sum8), last8);
         end
      end
   end

   // WIDTH=16 monitor.
   always @(negedge clk) begin
      if (!rst && done16) begin
         if (q16.size() == 0) begin
            chk("spur16", 64'd1, 64'd0);
         end else begin
            e16 = q16.pop_front();
            chk("sum16", 64'(sum16), e16.sum);
            chk("cout16", 64'(cout16), 64'(e16.cout));
            chk("ovf16", 64'(ovf16), 64'(e16.ovf));
            chk("lat16", 64'(cyc - e16.t), 64'd17);
         end
      end
   end

   // WIDTH=2 monitor.
   always @(negedge clk) begin
      if (!rst && done2) begin
         if (q2.size() == 0) begin
            chk("spur2", 64'd1, 64'd0);
         end else begin
            e2 = q2.pop_front();
            chk("sum2", 64'(sum2), e2.sum);
            chk("cout2", 64'(cout2), 64'(e2.cout));
            chk("ovf2", 64'(ovf2), 64'(e2.ovf));
            chk("lat2", 64'(cyc - e2.t), 64'd3);
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_sum", 64'(sum8), 64'd0);
      chk("rst_cout", 64'(cout8), 64'd0);
      chk("rst_ovf", 64'(ovf8), 64'd0);
      chk("rst_state", 64'(u8.r_state), 64'd0);

      op8(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
      op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op8(8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0);
      op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

      // Abort an operation mid-RUN.
      a8 = 8'd100;
      b8 = 8'd27;
      sub8 = 1'b0;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      nd0 = n_done8;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy8), 64'd0);
      chk("abort_done", 64'(done8), 64'd0);
      chk("abort_sum", 64'(sum8), 64'd0);
      chk("abort_cout", 64'(cout8), 64'd0);
      chk("abort_ovf", 64'(ovf8), 64'd0);
      chk("abort_state", 64'(u8.r_state), 64'd0);
      repeat (15) @(negedge clk);
      chk("abort_nodone", 64'(n_done8 - nd0), 64'd0);

      // start held high, operands scrambled while running.
      stab_en = 1'b1;
      start8 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         sub8 = 1'($urandom);
         q8.push_back(model(64'(a8), 64'(b8), sub8, 8, cyc));
         @(negedge clk);
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         sub8 = ~sub8;
         repeat (8) @(negedge clk);
      end
      start8 = 1'b0;
      drain8();
      stab_en = 1'b0;

      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               a16 = 16'($urandom);
               b16 = 16'($urandom);
               sub16 = 1'($urandom);
               q16.push_back(model(64'(a16), 64'(b16), sub16, 16, cyc));
               start16 = 1'b1;
               @(negedge clk);
               start16 = 1'b0;
               a16 = ~a16;
               repeat (16) @(negedge clk);
            end
            for (int n = 0; n < 100 && q16.size() != 0; n++)
               @(negedge clk);
            chk("drain16", 64'(q16.size()), 64'd0);
         end
         begin
            for (int i = 0; i < 1000; i++) begin
               a2 = 2'($urandom);
               b2 = 2'($urandom);
               sub2 = 1'($urandom);
               q2.push_back(model(64'(a2), 64'(b2), sub2, 2, cyc));
               start2 = 1'b1;
               @(negedge clk);
               start2 = 1'b0;
               b2 = ~b2;
               repeat (2) @(negedge clk);
            end
            for (int n = 0; n < 100 && q2.size() != 0; n++)
               @(negedge clk);
            chk("drain2", 64'(q2.size()), 64'd0);
         end
      join

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
